// File: rtl/dpram_bclr.sv
// rtl/dpram_bclr.sv - dual-port RAM with per-byte writes, write-first bypass and a clear sequencer
module dpram_bclr #(
  parameter int            AW   = 5,
  parameter int            DW   = 32,
  parameter logic [DW-1:0] CLRV = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ena_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic            wre_i,
  output logic [DW-1:0]   dat_o,
  input  logic [AW-1:0]   xadr_i,
  output logic [DW-1:0]   xdat_o,
  input  logic            clr_i,
  output logic            bsy_o
);

  localparam int NB = DW / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [AW-1:0] r_cnt;
  logic          w_bsy;
  logic          w_we;
  logic [DW-1:0] w_old;
  logic [DW-1:0] w_merged;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_xdat;
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
    end
  end

  // The sweep ends on the edge that writes the top address; clr_i is only honoured in IDLE.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (clr_i) w_nstate = S_CLEAR;
      S_CLEAR: if (r_cnt == {AW{1'b1}}) w_nstate = S_IDLE;
      default: w_nstate = S_CLEAR;
    endcase
  end

  always_comb begin
    w_bsy = (r_state == S_CLEAR);
  end

  assign w_we  = ena_i & wre_i & ~w_bsy;
  assign w_old = r_mem[adr_i];

  always_comb begin
    w_merged = w_old;
    for (int n = 0; n < NB; n++) begin
      if (sel_i[n]) w_merged[8*n +: 8] = dat_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_bsy)     r_mem[r_cnt] <= CLRV;
    else if (w_we) r_mem[adr_i] <= w_merged;
  end

  // Both read ports see the merged word when they address the word being written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dat  <= '0;
      r_xdat <= '0;
    end else if (ena_i && !w_bsy) begin
      r_dat  <= w_we ? w_merged : w_old;
      r_xdat <= (w_we && (xadr_i == adr_i)) ? w_merged : r_mem[xadr_i];
    end
  end

  assign dat_o  = r_dat;
  assign xdat_o = r_xdat;
  assign bsy_o  = w_bsy;

endmodule
